// File: rtl/adder_pkg.sv
// adder_pkg: shared encodings for the switch adder/accumulator.
// Mode codes and controller FSM states.
package adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXEC     = 2'b01,
    DONE     = 2'b10,
    WAIT_REL = 2'b11
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop sync, stability counter, rising-edge press.
// Stays disarmed after reset until the button is seen released.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          armed;
  logic [CW-1:0] cnt;

  // Sync, then accept a level only after DEB_CYCLES stable samples
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      if (!armed) begin
        if (s1 | s2) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          armed <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        press <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_accum_ctrl.sv
// adder_accum_ctrl: press-triggered add/sub/accumulate on switch operands.
// Define ACC_SATURATE_EN to clamp results instead of wrapping.
module adder_accum_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 50000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [1:0]       Mode,
  input  logic             Btn0,
  output logic [WIDTH:0]   Output,
  output logic             Valid,
  output logic             Busy
);

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [WIDTH:0] MAXV = {1'b1, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] MINV = {1'b1, {WIDTH{1'b0}}};

  state_e           state;
  state_e           nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]   res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH:0]   asum;
  logic             press;
  logic             level;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk  (Clk),
    .rst  (Rst),
    .btn  (Btn0),
    .level(level),
    .press(press)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: one operation per press, then wait for release
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (press) nxt = EXEC;
      EXEC:     nxt = DONE;
      DONE:     nxt = WAIT_REL;
      WAIT_REL: if (!level) nxt = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    Valid = (state == DONE);
    Busy  = (state != IDLE);
  end

  // Arithmetic at WIDTH+1 bits; top bit is carry/borrow/overflow
  always_comb begin
    sum     = {1'b0, OpA} + {1'b0, OpB};
    dif     = {1'b0, OpA} - {1'b0, OpB};
    asum    = {1'b0, acc} + {1'b0, OpA};
    res     = '0;
    acc_nxt = acc;
    unique case (Mode)
      MODE_ADD: res = (SAT && sum[WIDTH]) ? MAXV : sum;
      MODE_SUB: res = (SAT && dif[WIDTH]) ? MINV : dif;
      MODE_ACC: begin
        res     = (SAT && asum[WIDTH]) ? MAXV : asum;
        acc_nxt = res[WIDTH-1:0];
      end
      MODE_CLR: begin
        res     = '0;
        acc_nxt = '0;
      end
    endcase
  end

  // Output and accumulator load on the EXEC -> DONE edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Output <= '0;
      acc    <= '0;
    end else if (state == EXEC) begin
      Output <= res;
      acc    <= acc_nxt;
    end
  end

endmodule
